axil_slave_regbank: RTL and testbench
=====================================

AXIL_SLAVE_REGBANK -- requirements
Module: axil_slave_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning the data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, meaning the byte address width (4 registers at offsets 0x0, 0x4, 0x8, 0xC).
REQ-003 SHALL have port s00_axi_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port s00_axi_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s00_axi_awaddr (input, ADDR_WIDTH), s00_axi_awprot (input, 3), s00_axi_awvalid (input, 1) and s00_axi_awready (output, 1): the write address channel.
REQ-006 SHALL have ports s00_axi_wdata (input, 32), s00_axi_wstrb (input, 4), s00_axi_wvalid (input, 1) and s00_axi_wready (output, 1): the write data channel.
REQ-007 SHALL have ports s00_axi_bresp (output, 2), s00_axi_bvalid (output, 1) and s00_axi_bready (input, 1): the write response channel.
REQ-008 SHALL have ports s00_axi_araddr (input, ADDR_WIDTH), s00_axi_arprot (input, 3), s00_axi_arvalid (input, 1) and s00_axi_arready (output, 1): the read address channel.
REQ-009 SHALL have ports s00_axi_rdata (output, 32), s00_axi_rresp (output, 2), s00_axi_rvalid (output, 1) and s00_axi_rready (input, 1): the read data channel.
REQ-010 SHALL have ports slv_reg0_o, slv_reg1_o, slv_reg2_o and slv_reg3_o, each output, 32 bits: the current register contents.

Function
REQ-011 SHALL accept AW and W independently, in either order or in the same cycle, latching each into a held flag plus a holding register.
REQ-012 SHALL drive awready=1 exactly when there is no held AW and bvalid=0; wready=1 exactly when there is no held W and bvalid=0.
REQ-013 SHALL commit the write at the edge where both an address and data are available (handshaking this cycle or already held), set bvalid=1 at that same edge, and clear both held flags.
REQ-014 SHALL apply wstrb per byte: byte n of the selected register updates only if wstrb[n]=1; wstrb=0 leaves the register unchanged but still yields a response.
REQ-015 SHALL select the register by address bits [3:2]; awprot and arprot are ignored.
REQ-016 SHALL hold bvalid and bresp stable until the edge where bready=1, then clear bvalid; no new AW or W is accepted while bvalid=1.
REQ-017 SHALL drive arready=1 exactly when rvalid=0; on an AR handshake, SHALL latch rdata and rresp and set rvalid=1 at the next edge, giving 1-cycle latency.
REQ-018 SHALL hold rdata, rresp and rvalid stable until the edge where rready=1, then clear rvalid; arready returns high in the following cycle.
REQ-019 SHALL run the read and write paths concurrently; a read that handshakes on the same edge a write commits to the same register SHALL return the pre-write value.
REQ-020 SHALL drive bresp and rresp to OKAY (2'b00) except as stated under REQ-024.

Reset
REQ-021 SHALL, while s00_axi_aresetn=0, force asynchronously: all registers to 0; awready, wready, arready, bvalid and rvalid to 0; bresp, rresp and rdata to 0; held flags cleared.
REQ-022 SHALL discard any partially collected or pending transaction on reset mid-operation and issue no response for it afterward.
REQ-023 SHALL raise ready outputs no earlier than the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL, with macro AXIL_REGBANK_SLVERR_EN defined, respond SLVERR (2'b10) to any access with address[1:0]!=0: no register is modified, and a read returns rdata=0.
REQ-025 SHALL, without AXIL_REGBANK_SLVERR_EN, ignore address[1:0] and always respond OKAY.

Verification
REQ-026 Bench SHALL cover: AW and W simultaneous, writing 0x00000001..0x00000004 to 0x0..0xC, then reading back -> rdata 1,2,3,4, resp OKAY, bvalid 1 cycle after handshake.
REQ-027 Bench SHALL cover: W issued 3 cycles before AW, data 0xDEADBEEF to 0x8 -> no bvalid until AW arrives, then slv_reg2_o=0xDEADBEEF.
REQ-028 Bench SHALL cover: reg1=0xFFFFFFFF, then write 0x12345678 with wstrb=4'b0101 -> reg1=0xFF34FF78.
REQ-029 Bench SHALL cover: bready held 0 for 5 cycles -> bvalid stays 1, awready and wready stay 0; read with rready held low -> rdata stable.
REQ-030 Bench SHALL cover: aresetn pulsed low with AW held but W pending -> all outputs 0; after reset, a W alone produces no bvalid.
REQ-031 Bench SHALL cover, with the macro defined: a write to 0x5 -> bresp=2'b10 and registers unchanged; a read of 0x6 -> rresp=2'b10, rdata=0.

Source files
------------

// File: rtl/axil_slave_regbank.sv
// axil_slave_regbank: AXI4-Lite slave exposing four 32-bit read/write registers.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock (rising edge), asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w*       : write address and write data channels, accepted independently
//   s00_axi_b*                     : write response channel
//   s00_axi_ar* / s00_axi_r*       : read address and read data channels (1-cycle read latency)
//   slv_reg0_o .. slv_reg3_o       : live register contents
//
// Build option: define AXIL_REGBANK_SLVERR_EN to answer SLVERR to accesses whose
// address[1:0] != 0; such writes are dropped and such reads return zero.
module axil_slave_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3_o
);
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    logic                                   rdy_en_q, rdy_en_d;
    logic                                   aw_held_q, aw_held_d;
    logic [3:0]                             aw_addr_q, aw_addr_d;
    logic                                   w_held_q, w_held_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]          w_data_q, w_data_d;
    logic [NB-1:0]                          w_strb_q, w_strb_d;
    logic                                   bvalid_q, bvalid_d;
    logic [1:0]                             bresp_q, bresp_d;
    logic                                   rvalid_q, rvalid_d;
    logic [1:0]                             rresp_q, rresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0]     regs_q, regs_d;

    logic                                   aw_hs, w_hs, ar_hs, commit, w_err, r_err, unused_ok;
    logic [3:0]                             wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]          wr_data;
    logic [NB-1:0]                          wr_strb;

    // Ready outputs stay low until the first edge after reset releases.
    assign s00_axi_awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
    assign s00_axi_wready  = rdy_en_q & ~w_held_q & ~bvalid_q;
    assign s00_axi_arready = rdy_en_q & ~rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign slv_reg0_o      = regs_q[0];
    assign slv_reg1_o      = regs_q[1];
    assign slv_reg2_o      = regs_q[2];
    assign slv_reg3_o      = regs_q[3];

    assign aw_hs   = s00_axi_awvalid & s00_axi_awready;
    assign w_hs    = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs   = s00_axi_arvalid & s00_axi_arready;
    // Each half comes either from its holding register or from this cycle's handshake.
    assign wr_addr = aw_held_q ? aw_addr_q : s00_axi_awaddr[3:0];
    assign wr_data = w_held_q ? w_data_q : s00_axi_wdata;
    assign wr_strb = w_held_q ? w_strb_q : s00_axi_wstrb;
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);

`ifdef AXIL_REGBANK_SLVERR_EN
    assign w_err     = wr_addr[1:0] != 2'b00;
    assign r_err     = s00_axi_araddr[1:0] != 2'b00;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot};
`else
    assign w_err     = 1'b0;
    assign r_err     = 1'b0;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, wr_addr[1:0], s00_axi_araddr[1:0]};
`endif

    always_comb begin
        rdy_en_d  = 1'b1;
        aw_held_d = commit ? 1'b0 : (aw_held_q | aw_hs);
        aw_addr_d = aw_hs ? s00_axi_awaddr[3:0] : aw_addr_q;
        w_held_d  = commit ? 1'b0 : (w_held_q | w_hs);
        w_data_d  = w_hs ? s00_axi_wdata : w_data_q;
        w_strb_d  = w_hs ? s00_axi_wstrb : w_strb_q;
        bvalid_d  = commit | (bvalid_q & ~s00_axi_bready);
        bresp_d   = commit ? {w_err, 1'b0} : bresp_q;
        rvalid_d  = ar_hs | (rvalid_q & ~s00_axi_rready);
        rresp_d   = ar_hs ? {r_err, 1'b0} : rresp_q;
        // Reads sample regs_q, so a same-edge write to the same register is not visible.
        rdata_d   = ar_hs ? (r_err ? '0 : regs_q[s00_axi_araddr[3:2]]) : rdata_q;
        regs_d    = regs_q;
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < NB; b++)
                if (commit && !w_err && wr_addr[3:2] == r[1:0] && wr_strb[b])
                    regs_d[r][8*b +: 8] = wr_data[8*b +: 8];
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            regs_q    <= '0;
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_axil_slave_regbank.sv
// tb_axil_slave_regbank: self-checking bench for axil_slave_regbank (table vectors, corner sequences, random traffic vs. an array model).
module tb_axil_slave_regbank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, reg0, reg1, reg2, reg3;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [4];

    axil_slave_regbank dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .slv_reg0_o(reg0), .slv_reg1_o(reg1), .slv_reg2_o(reg2), .slv_reg3_o(reg3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit addr_err(input logic [3:0] a);
`ifdef AXIL_REGBANK_SLVERR_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!addr_err(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic check_regs(input string name);
        check(name, {reg3, reg2, reg1, reg0}, {model[3], model[2], model[1], model[0]});
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_dly;
            awaddr  = a;
            wvalid  = !w_done && cyc >= w_dly;
            wdata   = d;
            wstrb   = s;
            @(negedge clk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("write_handshake", {aw_done, w_done}, 2'b11);
        check("bvalid_after_hs", bvalid, 1'b1);
        resp   = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit fire = 0;
        int cyc = 0;
        arvalid = 1'b1;
        araddr  = a;
        while (!fire && cyc < 50) begin
            @(negedge clk);
            fire = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check("read_latency", {fire, rvalid}, 2'b11);
        d      = rdata;
        resp   = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vt [10];
        logic [1:0]  resp;
        logic [31:0] d;
        logic [31:0] stable;
        logic [31:0] sel [4];

        vt[0] = '{1, 4'h0, 32'h1, 4'hF, 32'h1};
        vt[1] = '{1, 4'h4, 32'h2, 4'hF, 32'h2};
        vt[2] = '{1, 4'h8, 32'h3, 4'hF, 32'h3};
        vt[3] = '{1, 4'hC, 32'h4, 4'hF, 32'h4};
        vt[4] = '{0, 4'h0, 32'h0, 4'h0, 32'h1};
        vt[5] = '{0, 4'h4, 32'h0, 4'h0, 32'h2};
        vt[6] = '{0, 4'h8, 32'h0, 4'h0, 32'h3};
        vt[7] = '{0, 4'hC, 32'h0, 4'h0, 32'h4};
        vt[8] = '{1, 4'h4, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
        vt[9] = '{1, 4'h4, 32'h12345678, 4'b0101, 32'hFF34FF78};
        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset state, and readies held low until the first edge after release.
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'h0);
        check("reset_rdata", rdata, 32'h0);
        check_regs("reset_regs");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        check("ready_after_edge", {awready, wready, arready}, 3'b111);

        // Table: simultaneous AW/W writes, read-back, byte strobes.
        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, resp);
                check("tbl_bresp", resp, 2'b00);
                sel = '{reg0, reg1, reg2, reg3};
                check("tbl_reg", sel[vt[i].addr[3:2]], vt[i].exp);
                model[vt[i].addr[3:2]] = vt[i].exp;
            end else begin
                axi_read(vt[i].addr, d, resp);
                check("tbl_rresp", resp, 2'b00);
                check("tbl_rdata", d, vt[i].exp);
            end
        end

        // W three cycles ahead of AW.
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (3) begin
            check("early_w_no_bvalid", {bvalid, wready}, 2'b00);
            @(posedge clk); #1;
        end
        awvalid = 1'b1; awaddr = 4'h8;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("early_w_bvalid", bvalid, 1'b1);
        check("early_w_reg2", reg2, 32'hDEADBEEF);
        model[2] = 32'hDEADBEEF;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;

        // Response backpressure on the write channel.
        awvalid = 1'b1; awaddr = 4'hC; wvalid = 1'b1; wdata = 32'hCAFE0001; wstrb = 4'hF;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1;
        wdata = 32'h0BAD0BAD;
        repeat (5) begin
            check("bp_b_hold", {bvalid, bresp, awready, wready}, 5'b10000);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        model[3] = 32'hCAFE0001;
        check_regs("bp_b_regs");
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;

        // Read-data backpressure: rdata must not move.
        arvalid = 1'b1; araddr = 4'h8;
        @(posedge clk); #1;
        arvalid = 1'b0;
        stable = rdata;
        check("bp_r_data", stable, 32'hDEADBEEF);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_r_hold", {rvalid, arready, rdata}, {2'b10, 32'hDEADBEEF});
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("bp_r_arready", arready, 1'b1);

        // Reset with an AW collected but W still pending.
        awvalid = 1'b1; awaddr = 4'h4;
        @(posedge clk); #1;
        awvalid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("midrst_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'h0);
        check("midrst_rdata", rdata, 32'h0);
        check_regs("midrst_regs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (4) begin
            check("midrst_w_alone", bvalid, 1'b0);
            @(posedge clk); #1;
        end
        awvalid = 1'b1; awaddr = 4'h0;
        @(posedge clk); #1;
        awvalid = 1'b0;
        model[0] = 32'hA5A5A5A5;
        check("midrst_complete", bvalid, 1'b1);
        check_regs("midrst_complete_regs");
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;

`ifdef AXIL_REGBANK_SLVERR_EN
        axi_write(4'h5, 32'h77777777, 4'hF, 0, 0, resp);
        check("slverr_bresp", resp, 2'b10);
        check_regs("slverr_regs");
        axi_read(4'h6, d, resp);
        check("slverr_rresp", resp, 2'b10);
        check("slverr_rdata", d, 32'h0);
`endif

        // Random traffic against the model, with random AW/W skew.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  a;
            logic [31:0] wd;
            logic [3:0]  s;
            a  = 4'($urandom_range(0, 15));
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
                model_write(a, wd, s);
                check("rnd_bresp", resp, {addr_err(a), 1'b0});
                check_regs("rnd_regs");
            end else begin
                axi_read(a, d, resp);
                check("rnd_rresp", resp, {addr_err(a), 1'b0});
                check("rnd_rdata", d, addr_err(a) ? 32'h0 : model[a[3:2]]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
